// File: rtl/uart_cmd_decoder.sv
// ============================================================================
// Module   : uart_cmd_decoder
// Brief    : Frames code/address UART bytes into a validated command with
//            valid/ready output and coded error pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cmd_decoder #(
    parameter logic [7:0] MAX_CODE       = 8'h06,
    parameter logic [7:0] MAX_ADDR       = 8'd31,
    parameter int         TIMEOUT_CYCLES = 1600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       rx_err,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [7:0] cmd_code,
    output logic [7:0] cmd_addr,
    output logic       busy,
    output logic       err,
    output logic [2:0] err_code
);

    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = '1;

    localparam logic [1:0] c_WAIT_CODE = 2'd0;
    localparam logic [1:0] c_WAIT_ADDR = 2'd1;
    localparam logic [1:0] c_HOLD      = 2'd2;

    localparam logic [2:0] c_ERR_NONE     = 3'b000;
    localparam logic [2:0] c_ERR_RX       = 3'b001;
    localparam logic [2:0] c_ERR_BAD_CODE = 3'b010;
    localparam logic [2:0] c_ERR_BAD_ADDR = 3'b011;
    localparam logic [2:0] c_ERR_TIMEOUT  = 3'b100;
    localparam logic [2:0] c_ERR_OVERFLOW = 3'b101;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic               r_rx_err_q;
    logic [c_CNT_W-1:0] r_cnt;
    logic [7:0]         r_code;
    logic               r_cmd_valid;
    logic [7:0]         r_cmd_code;
    logic [7:0]         r_cmd_addr;
    logic               r_busy;
    logic               r_err;
    logic [2:0]         r_err_code;

    logic       w_err_rise;
    logic       w_handshake;
    logic       w_code_ok;
    logic       w_addr_ok;
    logic       w_timeout;
    logic       w_err_fire;
    logic [2:0] w_err_cause;
    logic       w_latch_code;
    logic       w_load_cmd;

    assign w_err_rise  = rx_err & ~r_rx_err_q;
    assign w_handshake = r_cmd_valid & cmd_ready;
    assign w_code_ok   = (rx_data <= MAX_CODE);
    assign w_addr_ok   = (rx_data <= MAX_ADDR);
    assign w_timeout   = (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_WAIT_CODE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_WAIT_CODE: begin
                if (!w_err_rise && rx_done && w_code_ok) begin
                    w_state_next = c_WAIT_ADDR;
                end
            end
            c_WAIT_ADDR: begin
                if (w_err_rise) begin
                    w_state_next = c_WAIT_CODE;
                end else if (rx_done) begin
                    w_state_next = w_addr_ok ? c_HOLD : c_WAIT_CODE;
                end else if (w_timeout) begin
                    w_state_next = c_WAIT_CODE;
                end
            end
            c_HOLD: begin
                // A byte arriving with the handshake starts the next frame.
                if (w_handshake) begin
                    w_state_next = (!w_err_rise && rx_done && w_code_ok) ? c_WAIT_ADDR
                                                                        : c_WAIT_CODE;
                end
            end
            default: w_state_next = c_WAIT_CODE;
        endcase
    end

    always_comb begin
        w_err_fire   = 1'b0;
        w_err_cause  = c_ERR_NONE;
        w_latch_code = 1'b0;
        w_load_cmd   = 1'b0;
        if (w_err_rise) begin
            w_err_fire  = 1'b1;
            w_err_cause = c_ERR_RX;
        end else begin
            case (r_state)
                c_WAIT_CODE: begin
                    if (rx_done) begin
                        if (w_code_ok) begin
                            w_latch_code = 1'b1;
                        end else begin
                            w_err_fire  = 1'b1;
                            w_err_cause = c_ERR_BAD_CODE;
                        end
                    end
                end
                c_WAIT_ADDR: begin
                    if (rx_done) begin
                        if (w_addr_ok) begin
                            w_load_cmd = 1'b1;
                        end else begin
                            w_err_fire  = 1'b1;
                            w_err_cause = c_ERR_BAD_ADDR;
                        end
                    end else if (w_timeout) begin
                        w_err_fire  = 1'b1;
                        w_err_cause = c_ERR_TIMEOUT;
                    end
                end
                c_HOLD: begin
                    if (rx_done) begin
                        if (!w_handshake) begin
                            w_err_fire  = 1'b1;
                            w_err_cause = c_ERR_OVERFLOW;
                        end else if (w_code_ok) begin
                            w_latch_code = 1'b1;
                        end else begin
                            w_err_fire  = 1'b1;
                            w_err_cause = c_ERR_BAD_CODE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_err_q  <= 1'b0;
            r_cnt       <= '0;
            r_code      <= 8'h00;
            r_cmd_valid <= 1'b0;
            r_cmd_code  <= 8'h00;
            r_cmd_addr  <= 8'h00;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= c_ERR_NONE;
        end else begin
            r_rx_err_q <= rx_err;
            r_busy     <= (w_state_next != c_WAIT_CODE);
            r_err      <= w_err_fire;
            if (w_err_fire) begin
                r_err_code <= w_err_cause;
            end
            if (w_latch_code) begin
                r_code <= rx_data;
            end
            // Saturating counter, restarted on every entry to WAIT_ADDR.
            if (w_latch_code) begin
                r_cnt <= '0;
            end else if (r_state == c_WAIT_ADDR && r_cnt != c_CNT_MAX) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
            if (w_load_cmd) begin
                r_cmd_valid <= 1'b1;
                r_cmd_code  <= r_code;
                r_cmd_addr  <= rx_data;
            end else if (w_handshake) begin
                r_cmd_valid <= 1'b0;
            end
        end
    end

    assign cmd_valid = r_cmd_valid;
    assign cmd_code  = r_cmd_code;
    assign cmd_addr  = r_cmd_addr;
    assign busy      = r_busy;
    assign err       = r_err;
    assign err_code  = r_err_code;

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_decoder.sv
// ============================================================================
// Module   : tb_uart_cmd_decoder
// Brief    : Scoreboard bench for uart_cmd_decoder with directed frames.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_cmd_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       rx_err = 1'b0;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid;
    logic [7:0] cmd_code;
    logic [7:0] cmd_addr;
    logic       busy;
    logic       err;
    logic [2:0] err_code;

    uart_cmd_decoder #(
        .MAX_CODE       (8'h06),
        .MAX_ADDR       (8'd31),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .rx_err    (rx_err),
        .cmd_ready (cmd_ready),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .cmd_addr  (cmd_addr),
        .busy      (busy),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // len = expected number of cycles cmd_valid stays high; 0 = ended by reset
    typedef struct {
        logic [7:0] code;
        logic [7:0] addr;
        int         cyc;
        int         len;
    } cmd_t;
    typedef struct {
        logic [2:0] code;
        int         cyc;
    } err_t;

    cmd_t exp_cmd_q[$];
    err_t exp_err_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_cmd(input logic [7:0] c, input logic [7:0] a, input int at, input int len);
        cmd_t e;
        e.code = c; e.addr = a; e.cyc = at; e.len = len;
        exp_cmd_q.push_back(e);
    endtask

    task automatic exp_err(input logic [2:0] c, input int at);
        err_t e;
        e.code = c; e.cyc = at;
        exp_err_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Returns the cycle in which the strobe was driven.
    task automatic send_byte(input logic [7:0] b, output int s);
        rx_data = b;
        rx_done = 1'b1;
        s = cyc;
        tick();
        rx_done = 1'b0;
        rx_data = 8'h00;
    endtask

    // Monitor
    cmd_t cur;
    bit   active = 1'b0;
    bit   prev_valid = 1'b0;
    int   hold = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            active     = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (err) begin
                if (exp_err_q.size() == 0) begin
                    chk("unexpected_err", {29'd0, err_code}, 32'hFFFF_FFFF);
                end else begin
                    err_t e;
                    e = exp_err_q.pop_front();
                    chk("err_code", {29'd0, err_code}, {29'd0, e.code});
                    chk("err_cycle", cyc, e.cyc);
                end
            end
            if (cmd_valid && !prev_valid) begin
                if (exp_cmd_q.size() == 0) begin
                    chk("unexpected_cmd", {16'd0, cmd_code, cmd_addr}, 32'hFFFF_FFFF);
                end else begin
                    cur = exp_cmd_q.pop_front();
                    active = 1'b1;
                    hold = 1;
                    chk("cmd_code", {24'd0, cmd_code}, {24'd0, cur.code});
                    chk("cmd_addr", {24'd0, cmd_addr}, {24'd0, cur.addr});
                    chk("cmd_cycle", cyc, cur.cyc);
                end
            end else if (cmd_valid && active) begin
                hold++;
                chk("cmd_code_stable", {24'd0, cmd_code}, {24'd0, cur.code});
                chk("cmd_addr_stable", {24'd0, cmd_addr}, {24'd0, cur.addr});
            end else if (!cmd_valid && prev_valid && active) begin
                chk("cmd_valid_len", hold, cur.len);
                active = 1'b0;
            end
            prev_valid = cmd_valid;
        end
    end

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_cmd_valid"}, {31'd0, cmd_valid}, 32'd0);
        chk({tag, "_cmd_code"}, {24'd0, cmd_code}, 32'd0);
        chk({tag, "_cmd_addr"}, {24'd0, cmd_addr}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        chk({tag, "_err_code"}, {29'd0, err_code}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s, c;
        rst_n = 1'b0;
        idle(3);
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        idle(2);

        // Normal frame with consumer always ready
        cmd_ready = 1'b1;
        send_byte(8'h02, s);
        chk("busy_wait_addr", {31'd0, busy}, 32'd1);
        send_byte(8'h05, s);
        exp_cmd(8'h02, 8'h05, s + 1, 1);
        idle(2);
        chk("busy_after_frame", {31'd0, busy}, 32'd0);

        // Backpressure: valid held s+1..s+7, overflow byte at s+3
        cmd_ready = 1'b0;
        send_byte(8'h01, s);
        send_byte(8'h03, s);
        exp_cmd(8'h01, 8'h03, s + 1, 7);
        idle(2);
        send_byte(8'h04, c);
        exp_err(3'b101, c + 1);
        idle(3);
        cmd_ready = 1'b1;
        idle(2);
        chk("busy_after_release", {31'd0, busy}, 32'd0);

        // Range checks
        send_byte(8'h07, s);
        exp_err(3'b010, s + 1);
        chk("busy_bad_code", {31'd0, busy}, 32'd0);
        idle(1);
        send_byte(8'h00, s);
        send_byte(8'h20, s);
        exp_err(3'b011, s + 1);
        idle(1);
        chk("busy_bad_addr", {31'd0, busy}, 32'd0);
        send_byte(8'h06, s);
        send_byte(8'h1F, s);
        exp_cmd(8'h06, 8'h1F, s + 1, 1);
        idle(2);

        // Handshake coinciding with the next code byte
        send_byte(8'h01, s);
        send_byte(8'h02, s);
        exp_cmd(8'h01, 8'h02, s + 1, 1);
        send_byte(8'h03, s);
        chk("busy_handshake_byte", {31'd0, busy}, 32'd1);
        send_byte(8'h04, s);
        exp_cmd(8'h03, 8'h04, s + 1, 1);
        idle(2);

        // Timeout boundary: address 16 cycles after code strobe is accepted
        send_byte(8'h01, c);
        idle(15);
        send_byte(8'h02, s);
        chk("timeout_edge_gap", s - c, 16);
        exp_cmd(8'h01, 8'h02, s + 1, 1);
        idle(2);

        // 17 cycles: timeout error, late byte becomes a code byte
        send_byte(8'h03, c);
        exp_err(3'b100, c + 17);
        idle(16);
        send_byte(8'h04, s);
        send_byte(8'h05, s);
        exp_cmd(8'h04, 8'h05, s + 1, 1);
        idle(2);

        // Receiver error one cycle after the code byte
        send_byte(8'h02, c);
        rx_err = 1'b1;
        exp_err(3'b001, c + 2);
        tick();
        rx_err = 1'b0;
        tick();
        chk("busy_after_rx_err", {31'd0, busy}, 32'd0);
        send_byte(8'h03, s);
        send_byte(8'h04, s);
        exp_cmd(8'h03, 8'h04, s + 1, 1);
        idle(2);

        // Asynchronous reset while a command is pending
        cmd_ready = 1'b0;
        send_byte(8'h01, s);
        send_byte(8'h01, s);
        exp_cmd(8'h01, 8'h01, s + 1, 0);
        idle(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("async_reset");
        tick();
        rst_n = 1'b1;
        cmd_ready = 1'b1;
        tick();
        send_byte(8'h01, s);
        send_byte(8'h01, s);
        exp_cmd(8'h01, 8'h01, s + 1, 1);
        idle(4);

        chk("err_queue_empty", exp_err_q.size(), 0);
        chk("cmd_queue_empty", exp_cmd_q.size(), 0);
        chk("cmd_closed", {31'd0, active}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
